// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller: access sizes and FSM states.
package dm_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/dm_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge (little-endian lanes).
module dm_byte_lane
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] oldWord,
  input  logic [31:0] newData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);
  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteVal    = oldWord[{offset, 3'b000} +: 8];
    halfVal    = oldWord[{offset[1], 4'b0000} +: 16];
    loadData   = oldWord;
    mergedWord = oldWord;
    case (size)
      SZ_BYTE: begin
        loadData = {{24{~isUnsigned & byteVal[7]}}, byteVal};
        mergedWord[{offset, 3'b000} +: 8] = newData[7:0];
      end
      SZ_HALF: begin
        loadData = {{16{~isUnsigned & halfVal[15]}}, halfVal};
        mergedWord[{offset[1], 4'b0000} +: 16] = newData[15:0];
      end
      default: begin
        loadData   = oldWord;
        mergedWord = newData;
      end
    endcase
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store initiator for the word-addressed data memory; sub-word stores run as read-modify-write.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output state_t            dbgState
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and the response (resp_valid) has no backpressure.
  state_t      state, nextState;
  logic        wrReg, unsReg;
  logic [1:0]  sizeReg, offReg;
  logic [31:0] wdataReg;
  logic        reqErr;
  logic [1:0]  reqOff;
  logic [31:0] laneLoad, laneMerge;

  always_comb begin
    reqErr = (req_size == SZ_RSVD);
    if (CHECK_ALIGN) begin
      if (req_size == SZ_HALF && req_addr[0]) reqErr = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) reqErr = 1'b1;
    end
    // Lane offset is forced to natural alignment, which only matters when CHECK_ALIGN=0.
    case (req_size)
      SZ_BYTE: reqOff = req_addr[1:0];
      SZ_HALF: reqOff = {req_addr[1], 1'b0};
      default: reqOff = 2'b00;
    endcase
  end

  dm_byte_lane u_lane (
    .size       (sizeReg),
    .isUnsigned (unsReg),
    .offset     (offReg),
    .oldWord    (mem_rdata),
    .newData    (wdataReg),
    .loadData   (laneLoad),
    .mergedWord (laneMerge)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (req_valid) begin
        if (reqErr)                             nextState = RESP;
        else if (req_wr && req_size == SZ_WORD) nextState = WR;
        else                                    nextState = RD;
      end
      RD:      nextState = wrReg ? WR : RESP;
      WR:      nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wrReg      <= 1'b0;
      unsReg     <= 1'b0;
      sizeReg    <= SZ_BYTE;
      offReg     <= 2'b00;
      wdataReg   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      state      <= nextState;
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          wrReg    <= req_wr;
          unsReg   <= req_unsigned;
          sizeReg  <= req_size;
          offReg   <= reqOff;
          wdataReg <= req_wdata;
          if (reqErr) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_wr && req_size == SZ_WORD) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        // The read word is consumed at the RD exit edge: merged into the store or extended for the load.
        RD: if (wrReg) begin
          mem_we    <= 1'b1;
          mem_wdata <= laneMerge;
        end else begin
          resp_valid <= 1'b1;
          resp_rdata <= laneLoad;
        end
        WR:      resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign dbgState  = state;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl against a behavioural word memory.
module tb_dm_access_ctrl;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = SZ_WORD;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  state_t      dbgState;

  int checks = 0;
  int errors = 0;

  dm_access_ctrl #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .dbgState(dbgState)
  );

  // clock / memory model / monitors
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int          weCount = 0, respCount = 0, acceptCount = 0;
  int          cycle = 0, lastAccept = 0, prevAccept = 0;
  logic [31:0] lastWeAddr = '0, lastWeData = '0;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      weCount    <= weCount + 1;
      lastWeAddr <= mem_addr;
      lastWeData <= mem_wdata;
    end
    if (resp_valid) respCount <= respCount + 1;
    if (req_valid && req_ready) begin
      acceptCount <= acceptCount + 1;
      prevAccept  <= lastAccept;
      lastAccept  <= cycle;
    end
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one request, returns latency (edges from accept), load data and error flag
  task automatic doReq(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    check("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr = ~wr; req_size = SZ_WORD; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
    check("ready_busy", 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
    check("resp_drop", {31'd0, resp_valid}, 32'd0);
    check("rdata_drop", resp_rdata, 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        err;
  int          we0, rsp0, acc0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[8]  = 32'h1122_3344;
    mem[12] = 32'h8001_7FFF;
    mem[20] = 32'h1234_5678;

    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // word store then load
    we0 = weCount;
    doReq(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rdata, err);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we_pulses", 32'(weCount - we0), 32'd1);
    check("sw_we_addr", lastWeAddr, 32'h10);
    check("sw_we_data", lastWeData, 32'hDEAD_BEEF);
    check("sw_rdata", rdata, 32'd0);
    check("sw_err", 32'(err), 32'd0);
    doReq(1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, lat, rdata, err);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);

    // byte read-modify-write and byte loads
    we0 = weCount;
    doReq(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h1234_56AA, lat, rdata, err);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we_pulses", 32'(weCount - we0), 32'd1);
    check("sb_we_data", lastWeData, 32'h11AA_3344);
    check("sb_mem", mem[8], 32'h11AA_3344);
    doReq(1'b0, SZ_BYTE, 1'b0, 32'h22, 32'h0, lat, rdata, err);
    check("lb_rdata", rdata, 32'hFFFF_FFAA);
    doReq(1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0, lat, rdata, err);
    check("lbu_rdata", rdata, 32'h0000_00AA);
    doReq(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, lat, rdata, err);
    check("lb1_rdata", rdata, 32'h0000_0033);

    // halfword store and loads
    doReq(1'b1, SZ_HALF, 1'b0, 32'h22, 32'hCAFE_BEEF, lat, rdata, err);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_mem", mem[8], 32'hBEEF_3344);
    doReq(1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, lat, rdata, err);
    check("lh_hi_rdata", rdata, 32'hFFFF_8001);
    doReq(1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, lat, rdata, err);
    check("lhu_hi_rdata", rdata, 32'h0000_8001);
    doReq(1'b0, SZ_HALF, 1'b0, 32'h30, 32'h0, lat, rdata, err);
    check("lh_lo_rdata", rdata, 32'h0000_7FFF);
    check("lh_lo_lat", 32'(lat), 32'd2);

    // error responses: no memory activity, mem_addr keeps the last access
    we0 = weCount;
    doReq(1'b0, SZ_WORD, 1'b0, 32'h41, 32'h0, lat, rdata, err);
    check("err_lw_lat", 32'(lat), 32'd1);
    check("err_lw_err", 32'(err), 32'd1);
    check("err_lw_rdata", rdata, 32'd0);
    doReq(1'b1, SZ_HALF, 1'b0, 32'h43, 32'hFFFF, lat, rdata, err);
    check("err_sh_lat", 32'(lat), 32'd1);
    check("err_sh_err", 32'(err), 32'd1);
    doReq(1'b0, SZ_RSVD, 1'b0, 32'h40, 32'h0, lat, rdata, err);
    check("err_sz_lat", 32'(lat), 32'd1);
    check("err_sz_err", 32'(err), 32'd1);
    check("err_no_we", 32'(weCount - we0), 32'd0);
    check("err_addr_kept", mem_addr, 32'h30);

    // held req_valid: accepts spaced by load latency + 1
    acc0 = acceptCount; rsp0 = respCount;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = SZ_WORD; req_addr = 32'h10;
    for (int i = 0; i < 30 && acceptCount < acc0 + 3; i++) begin
      @(posedge clk); #1;
    end
    check("hold_accepts", 32'(acceptCount - acc0), 32'd3);
    check("hold_spacing", 32'(lastAccept - prevAccept), 32'd3);
    check("hold_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("hold_resps", 32'(respCount - rsp0), 32'd3);

    // reset during RD of a byte store
    we0 = weCount; rsp0 = respCount;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = SZ_BYTE; req_addr = 32'h51;
    req_wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_state", 32'(dbgState), 32'(RD));
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_we", 32'(weCount - we0), 32'd0);
    check("rst_mid_no_resp", 32'(respCount - rsp0), 32'd0);
    check("rst_mid_ready_after", 32'(req_ready), 32'd1);
    check("rst_mid_mem", mem[20], 32'h1234_5678);

    // normal operation after the reset
    doReq(1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0, lat, rdata, err);
    check("post_rst_lw", rdata, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Load/store access controller: the initiator side of the word-addressed data memory. It accepts one CPU load/store request at a time, with byte, halfword or word size. It drives the memory's address, write data and write enable, and returns sign- or zero-extended load data. The memory has only whole-word writes, so sub-word stores are done as a read-modify-write. The block sits between the datapath's MEM stage and the data memory.

Parameters:
ADDR_W, 32, width of request and memory byte address
CHECK_ALIGN, 1, 1: misaligned access returns error with no memory access; 0: low address bits are forced to alignment

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_wr  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores)
resp_err  output  1  valid with resp_valid: misaligned or reserved size
mem_addr  output  ADDR_W  word-aligned byte address to memory ({addr[ADDR_W-1:2],2'b00})
mem_wdata  output  32  full word written to memory
mem_we  output  1  memory write enable; memory commits on the rising edge while high
mem_rdata  input  32  combinational memory read data for mem_addr

Behaviour:
- Memory model: read is combinational from mem_addr; write is synchronous on posedge clk when mem_we=1.
- Byte order is little-endian: byte lane k is bits [8k+7:8k], selected by addr[1:0].
- States: IDLE, RD, WR, RESP. All outputs except req_ready are registered; req_ready = (state==IDLE).
- Reset (async) values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Accept: a request is accepted on a rising edge in IDLE with req_valid=1. The request fields are latched at acceptance; later input changes are ignored.
- Error check, applied at acceptance:
  - size 11 is always an error;
  - with CHECK_ALIGN=1, half with addr[0]=1 is an error;
  - with CHECK_ALIGN=1, word with addr[1:0]!=0 is an error.
- With CHECK_ALIGN=0, the lane offset is forced: half uses addr[1] only, word uses lane 0.
- Transitions:
  - error: IDLE->RESP; resp_err=1; no mem_we; mem_addr unchanged.
  - load: IDLE->RD->RESP.
  - word store: IDLE->WR->RESP.
  - byte/half store: IDLE->RD->WR->RESP.
  - RESP->IDLE always.
- RD: mem_addr holds the aligned address. mem_rdata is captured into an internal word register on the rising edge leaving RD.
- Load result: extract the lane(s), then sign- or zero-extend per req_unsigned. Word loads ignore req_unsigned.
- WR: mem_we=1 for exactly one cycle. mem_wdata is req_wdata for a word store. For sub-word stores it is the captured word with the addressed byte or halfword replaced by req_wdata[7:0] or [15:0].
- RESP: resp_valid=1 for exactly one cycle. resp_rdata holds the load value, or 0 for stores and errors. resp_valid and resp_rdata return to 0 next cycle.
- Latency from accept edge to resp_valid:
  - error: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- Throughput: req_ready is low in RD, WR and RESP. The next request is accepted in the IDLE cycle after RESP, so there are no back-to-back accepts.
- The response has no backpressure; the consumer must take resp_valid when it pulses.
- Reset mid-operation:
  - the FSM returns to IDLE immediately and any response is dropped;
  - asserting rst_n low during WR clears mem_we asynchronously, so the write is not committed unless the edge has already passed;
  - a read-modify-write interrupted in RD performs no write.
- mem_we is never high outside WR. mem_addr holds its value between operations.

Decomposition:
- Shared package dm_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum {IDLE, RD, WR, RESP}.
- Sub-module dm_byte_lane (purely combinational) performs load extract/extend and store merge, given size, unsigned, offset, old word and new data.
- The FSM and registers stay in dm_access_ctrl.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF -> one mem_we pulse, mem_addr 0x10. Then load word at 0x10 -> resp_rdata 0xDEADBEEF two cycles after accept.
- Byte RMW: memory at 0x20 holds 0x11223344; store byte 0xAA at 0x22 -> mem_wdata 0x11AA3344 and resp_valid three cycles after accept. Then lb at 0x22 -> 0xFFFFFFAA; lbu at 0x22 -> 0x000000AA.
- Halfword: memory at 0x30 holds 0x8001_7FFF. lh at 0x32 -> 0xFFFF8001; lhu at 0x32 -> 0x00008001; lh at 0x30 -> 0x00007FFF.
- Errors (CHECK_ALIGN=1):
  - lw at 0x41 -> resp_err=1 one cycle after accept, mem_we never high;
  - sh at 0x43 -> same;
  - size 11 -> same.
- Handshake: hold req_valid high continuously -> req_ready low from the accept cycle through RESP, and accepts are spaced by latency+1 cycles.
- Reset mid-RMW: drive rst_n low while in RD of a sb -> no mem_we ever and no resp_valid; after release, req_ready=1 and memory is unchanged.
